// File: rtl/usb_pkg.sv
// Shared definitions for the USB full-speed transmitter: line states, SYNC
// pattern, CRC16 constants and FSM state encoding (CRC state only with USB_TX_CRC16_EN).
package usb_pkg;

   // Line level as {D+, D-}
   typedef logic [1:0] line_t;
   localparam line_t LINE_J   = 2'b10;
   localparam line_t LINE_K   = 2'b01;
   localparam line_t LINE_SE0 = 2'b00;

   // Sent LSB first: 0,0,0,0,0,0,0,1
   localparam logic [7:0] SYNC_PATTERN = 8'h80;

   localparam logic [15:0] CRC16_POLY = 16'h8005;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_DATA,
`ifdef USB_TX_CRC16_EN
      ST_CRC,
`endif
      ST_EOP_SE0,
      ST_EOP_J
   } tx_state_t;

   function automatic line_t line_flip(input line_t l);
      return (l == LINE_J) ? LINE_K : LINE_J;
   endfunction

   function automatic logic [15:0] bit_rev16(input logic [15:0] v);
      logic [15:0] r;
      for (int unsigned i = 0; i < 16; i++) r[i] = v[15 - i];
      return r;
   endfunction

endpackage

// File: rtl/usb_crc16.sv
// Serial CRC16 (x^16+x^15+x^2+1), one bit per enable, LSB-first data.
// Kept in reflected form so the complemented result is transmitted LSB first.
module usb_crc16
   import usb_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        clr,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc
);

   localparam logic [15:0] POLY_REFL = bit_rev16(CRC16_POLY);

   logic fb;
   assign fb = din ^ crc[0];

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)
         crc <= CRC16_INIT;
      else if (clr)
         crc <= CRC16_INIT;
      else if (en)
         crc <= {1'b0, crc[15:1]} ^ (fb ? POLY_REFL : '0);
   end

endmodule

// File: rtl/usb_tx.sv
// USB full-speed serial transmitter: SYNC, NRZI, bit stuffing, EOP.
// Define USB_TX_CRC16_EN to append a CRC16 (needs CLKS_PER_BIT >= 2).
module usb_tx
   import usb_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [7:0] TxData,
   input  logic       TxValid,
   output logic       TxReady,
   output logic       D_P_Out,
   output logic       D_N_Out,
   output logic       OE,
   output logic       Busy
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   tx_state_t   state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]  bidx, bidx_n;
   logic [15:0] sreg, sreg_n;
   logic        stuff, stuff_n;
   logic [2:0]  ones, ones_n;
   line_t       nrzi, nrzi_n;
   logic        have_next, have_next_n;
   logic [7:0]  nxt_byte, nxt_byte_n;
   logic        pid, pid_n;

   logic        cell_start, cell_end, cur_bit, load_pt;
   logic [3:0]  last_idx;

`ifdef USB_TX_CRC16_EN
   logic [15:0] crc_val;

   usb_crc16 u_crc (
      .Clk   (Clk),
      .Reset (Reset),
      .clr   (state == ST_IDLE),
      .en    (state == ST_DATA && cell_start && !stuff && !pid),
      .din   (sreg[0]),
      .crc   (crc_val)
   );

   assign last_idx = (state == ST_CRC) ? 4'd15 : 4'd7;
`else
   assign last_idx = 4'd7;
`endif

   assign cell_start = (cnt == '0);
   assign cell_end   = (cnt == CNT_LAST);
   assign cur_bit    = !stuff && sreg[0];
   assign load_pt    = (state == ST_SYNC || state == ST_DATA) && cell_start
                       && !stuff && (bidx == 4'd7);
   assign TxReady    = load_pt && TxValid;

   assign OE   = (state != ST_IDLE);
   assign Busy = OE;
   assign {D_P_Out, D_N_Out} = (state == ST_EOP_SE0) ? LINE_SE0 : nrzi;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         bidx      <= '0;
         sreg      <= '0;
         stuff     <= 1'b0;
         ones      <= '0;
         nrzi      <= LINE_J;
         have_next <= 1'b0;
         nxt_byte  <= '0;
         pid       <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         bidx      <= bidx_n;
         sreg      <= sreg_n;
         stuff     <= stuff_n;
         ones      <= ones_n;
         nrzi      <= nrzi_n;
         have_next <= have_next_n;
         nxt_byte  <= nxt_byte_n;
         pid       <= pid_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cell_end ? '0 : cnt + 1'b1;
      bidx_n      = bidx;
      sreg_n      = sreg;
      stuff_n     = stuff;
      ones_n      = ones;
      nrzi_n      = nrzi;
      have_next_n = have_next;
      nxt_byte_n  = nxt_byte;
      pid_n       = pid;

      if (TxReady) begin
         have_next_n = 1'b1;
         nxt_byte_n  = TxData;
      end else if (load_pt) begin
         have_next_n = 1'b0;
      end

      case (state)
         ST_IDLE: begin
            cnt_n = '0;
            if (TxValid) begin
               state_n     = ST_SYNC;
               bidx_n      = '0;
               sreg_n      = {8'h00, SYNC_PATTERN};
               stuff_n     = 1'b0;
               ones_n      = '0;
               have_next_n = 1'b0;
               nrzi_n      = SYNC_PATTERN[0] ? LINE_J : LINE_K;
            end
         end

         ST_EOP_SE0: begin
            if (cell_end) begin
               bidx_n = bidx + 4'd1;
               if (bidx == 4'd1) begin
                  state_n = ST_EOP_J;
                  bidx_n  = '0;
               end
            end
         end

         ST_EOP_J: begin
            if (cell_end) state_n = ST_IDLE;
         end

         default: begin
            if (cell_end) begin
               ones_n = cur_bit ? ones + 3'd1 : 3'd0;
               if (ones_n == 3'd6) begin
                  // Stuffed 0 cell: shifter and bit index hold until it ends
                  stuff_n = 1'b1;
                  nrzi_n  = line_flip(nrzi);
               end else begin
                  stuff_n = 1'b0;
                  if (bidx != last_idx) begin
                     sreg_n = {1'b0, sreg[15:1]};
                     bidx_n = bidx + 4'd1;
                  end else if (have_next) begin
                     state_n = ST_DATA;
                     sreg_n  = {8'h00, nxt_byte};
                     bidx_n  = '0;
                     pid_n   = (state == ST_SYNC);
                  end
`ifdef USB_TX_CRC16_EN
                  else if (state == ST_DATA) begin
                     state_n = ST_CRC;
                     sreg_n  = ~crc_val;
                     bidx_n  = '0;
                  end
`endif
                  else begin
                     state_n = ST_EOP_SE0;
                     bidx_n  = '0;
                     ones_n  = '0;
                  end

                  if (state_n == ST_EOP_SE0)
                     nrzi_n = LINE_J;
                  else
                     nrzi_n = sreg_n[0] ? nrzi : line_flip(nrzi);
               end
            end
         end
      endcase
   end

endmodule

// File: tb/tb_usb_tx.sv
// Self-checking bench for usb_tx: line decoder plus byte/length scoreboard.
module tb_usb_tx;

   localparam int unsigned CPB = 4;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic [7:0] TxData = '0;
   logic       TxValid = 1'b0;
   logic       TxReady, D_P_Out, D_N_Out, OE, Busy;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned cyc     = 0;

   typedef struct {
      int unsigned oe;
      int unsigned cells;
   } pkt_exp_t;

   pkt_exp_t    mod_q[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  pkt[$];
   logic [7:0]  crc_exp[2];
   int unsigned rdy_t[8];
   int unsigned rdy_n;

   usb_tx #(.CLKS_PER_BIT(CPB)) dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .TxData  (TxData),
      .TxValid (TxValid),
      .TxReady (TxReady),
      .D_P_Out (D_P_Out),
      .D_N_Out (D_N_Out),
      .OE      (OE),
      .Busy    (Busy)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference CRC in the textbook shift-left form, complemented, sent MSB first
   function automatic logic [15:0] crc16_ref();
      logic [15:0] c = 16'hFFFF;
      logic [7:0]  cur;
      logic        fb;
      for (int i = 1; i < pkt.size(); i++) begin
         cur = pkt[i];
         for (int b = 0; b < 8; b++) begin
            fb = cur[b] ^ c[15];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
         end
      end
      return ~c;
   endfunction

   task automatic push_model();
      logic [7:0]  wb[$];
      logic [7:0]  cur;
      logic [15:0] r;
      int unsigned ones  = 1;
      int unsigned cells = 8;
      pkt_exp_t    e;
      wb = pkt;
`ifdef USB_TX_CRC16_EN
      r = crc16_ref();
      for (int i = 0; i < 8; i++) begin
         crc_exp[0][i] = r[15 - i];
         crc_exp[1][i] = r[7 - i];
      end
      wb.push_back(crc_exp[0]);
      wb.push_back(crc_exp[1]);
`else
      r = '0;
      crc_exp[0] = r[7:0];
      crc_exp[1] = r[15:8];
`endif
      foreach (wb[i]) begin
         cur = wb[i];
         for (int b = 0; b < 8; b++) begin
            cells++;
            ones = cur[b] ? ones + 1 : 0;
            if (ones == 6) begin
               cells++;
               ones = 0;
            end
         end
      end
      e.oe    = (cells + 3) * CPB;
      e.cells = cells;
      mod_q.push_back(e);
   endtask

   task automatic run_bytes(input int unsigned n, input bit stop);
      int unsigned t;
      rdy_n = 0;
      for (int unsigned i = 0; i < n; i++) begin
         t = 0;
         do begin
            @(negedge Clk);
            t++;
         end while (!TxReady && t < 400);
         check("rdy_seen", TxReady, 1'b1);
         if (!TxReady) begin
            TxValid = 1'b0;
            return;
         end
         exp_q.push_back(pkt[i]);
         rdy_t[rdy_n] = cyc;
         rdy_n++;
         @(posedge Clk);
         #1;
         if (i + 1 < pkt.size() && !(stop && i + 1 == n)) TxData = pkt[i + 1];
         if (stop && i + 1 == n) TxValid = 1'b0;
      end
`ifdef USB_TX_CRC16_EN
      if (stop) begin
         exp_q.push_back(crc_exp[0]);
         exp_q.push_back(crc_exp[1]);
      end
`endif
   endtask

   task automatic wait_idle();
      int unsigned t = 0;
      do begin
         @(negedge Clk);
         t++;
      end while (Busy && t < 2000);
      check("idle_reached", Busy, 1'b0);
   endtask

   task automatic send();
      push_model();
      @(posedge Clk);
      #1;
      TxValid = 1'b1;
      TxData  = pkt[0];
      run_bytes(pkt.size(), 1'b1);
      wait_idle();
   endtask

   // Line monitor: NRZI decode, destuff, byte compare, EOP and length checks
   logic        in_pkt = 1'b0;
   int unsigned oe_cnt, se0_cells, j_cells, data_cells, m_ones, nbits, nbytes;
   logic [7:0]  sh;
   logic [1:0]  prev, sym;
   logic        bitv;
   pkt_exp_t    me;

   always @(negedge Clk) begin
      sym = {D_P_Out, D_N_Out};
      if (!Reset) begin
         in_pkt = 1'b0;
      end else if (OE) begin
         if (!in_pkt) begin
            in_pkt = 1'b1;
            oe_cnt = 0; se0_cells = 0; j_cells = 0; data_cells = 0;
            m_ones = 0; nbits = 0; nbytes = 0; sh = '0; prev = 2'b10;
            check("busy_rise", Busy, 1'b1);
         end
         if (oe_cnt % CPB == CPB / 2) begin
            if (sym == 2'b00) begin
               se0_cells++;
            end else if (sym == 2'b11) begin
               check("line_se1", sym, 2'b10);
            end else if (se0_cells != 0) begin
               check("eop_j", sym, 2'b10);
               j_cells++;
            end else begin
               data_cells++;
               bitv = (sym == prev);
               prev = sym;
               if (m_ones == 6) begin
                  check("stuff_bit", bitv, 1'b0);
                  m_ones = 0;
               end else begin
                  m_ones = bitv ? m_ones + 1 : 0;
                  sh = {bitv, sh[7:1]};
                  nbits++;
                  if (nbits == 8) begin
                     nbits = 0;
                     if (nbytes == 0) begin
                        check("sync", sh, 8'h80);
                     end else begin
                        check("data_avail", exp_q.size() != 0, 1'b1);
                        if (exp_q.size() != 0) check("data", sh, exp_q.pop_front());
                     end
                     nbytes++;
                  end
               end
            end
         end
         oe_cnt++;
      end else if (in_pkt) begin
         in_pkt = 1'b0;
         check("busy_fall", Busy, 1'b0);
         check("idle_line", sym, 2'b10);
         check("se0_cells", se0_cells, 2);
         check("eop_j_cells", j_cells, 1);
         check("partial_bits", nbits, 0);
         check("data_missing", exp_q.size(), 0);
         check("model_avail", mod_q.size() != 0, 1'b1);
         if (mod_q.size() != 0) begin
            me = mod_q.pop_front();
            check("oe_clks", oe_cnt, me.oe);
            check("cells", data_cells, me.cells);
         end
      end
   end

   initial begin
      int unsigned t;

      TxValid = 1'b1;
      TxData  = 8'hFF;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      check("rst_oe", OE, 1'b0);
      check("rst_busy", Busy, 1'b0);
      check("rst_rdy", TxReady, 1'b0);
      check("rst_line", {D_P_Out, D_N_Out}, 2'b10);
      TxValid = 1'b0;
      @(posedge Clk);
      #1 Reset = 1'b1;
      repeat (3) @(negedge Clk);
      check("idle_oe", OE, 1'b0);

      pkt = '{8'hA5};
      send();
      check("a5_rdy_cnt", rdy_n, 1);

      pkt = '{8'hFF};
      send();
      check("ff_rdy_cnt", rdy_n, 1);

      pkt = '{8'h2D, 8'h00, 8'h10};
      send();
      check("3b_rdy_cnt", rdy_n, 3);
      check("3b_gap1", rdy_t[1] - rdy_t[0], 32);
      check("3b_gap2", rdy_t[2] - rdy_t[1], 32);

      // Abort mid-packet with reset during the second data byte
      pkt = '{8'h12, 8'h34, 8'h56};
      push_model();
      @(posedge Clk);
      #1;
      TxValid = 1'b1;
      TxData  = pkt[0];
      run_bytes(2, 1'b0);
      repeat (12) @(posedge Clk);
      #1 Reset = 1'b0;
      #1;
      check("abort_oe", OE, 1'b0);
      check("abort_busy", Busy, 1'b0);
      check("abort_rdy", TxReady, 1'b0);
      check("abort_line", {D_P_Out, D_N_Out}, 2'b10);
      TxValid = 1'b0;
      exp_q.delete();
      mod_q.delete();
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b1;
      repeat (2) @(negedge Clk);
      check("post_rst_oe", OE, 1'b0);

      pkt = '{8'h5A};
      send();

      // Back-to-back: next TxValid raised during EOP, restart right after OE falls
      pkt = '{8'h11};
      send_first: begin
         push_model();
         @(posedge Clk);
         #1;
         TxValid = 1'b1;
         TxData  = pkt[0];
         run_bytes(1, 1'b1);
      end
      t = 0;
      do begin
         @(negedge Clk);
         t++;
      end while ({D_P_Out, D_N_Out} != 2'b00 && t < 400);
      check("b2b_se0_seen", {D_P_Out, D_N_Out}, 2'b00);
      pkt = '{8'hC3, 8'h7E};
      push_model();
      TxValid = 1'b1;
      TxData  = pkt[0];
      t = 0;
      while (OE && t < 400) begin
         @(negedge Clk);
         t++;
      end
      check("b2b_gap_low", OE, 1'b0);
      @(negedge Clk);
      check("b2b_restart", OE, 1'b1);
      check("b2b_first_k", {D_P_Out, D_N_Out}, 2'b01);
      run_bytes(2, 1'b1);
      wait_idle();

`ifdef USB_TX_CRC16_EN
      pkt = '{8'hC3, 8'h00, 8'h01};
      send();
      check("crc_rdy_cnt", rdy_n, 3);
`endif

      repeat (4) @(negedge Clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/usb_tx.md
USB_TX -- requirements
Module: usb_tx

Interface
- REQ-001: Parameter CLKS_PER_BIT, default 4, Clk cycles per USB bit cell (48 MHz Clk gives 12 Mb/s full speed).
- REQ-002: Clk  input  1  system clock; all logic on rising edge.
- REQ-003: Reset  input  1  asynchronous, active-low reset.
- REQ-004: TxData  input  8  byte to send, LSB first; must be stable whenever TxValid=1.
- REQ-005: TxValid  input  1  high for the whole packet; low at a byte-load point ends the packet.
- REQ-006: TxReady  output  1  one-Clk pulse marking the cycle TxData is consumed.
- REQ-007: D_P_Out, D_N_Out  output  1 each  line levels; J = (1,0), K = (0,1), SE0 = (0,0).
- REQ-008: OE  output  1  bus drive enable for the external tristate pads.
- REQ-009: Busy  output  1  high from packet start until OE falls.

Function
- REQ-010: States: IDLE, SYNC, DATA, CRC (macro only), EOP_SE0, EOP_J.
- REQ-011: IDLE: OE=0, lines=J, TxReady=0; TxValid=1 moves to SYNC next Clk, with OE=1 from that Clk.
- REQ-012: Bit cell boundaries every CLKS_PER_BIT Clks from SYNC entry; line outputs change only at boundaries.
- REQ-013: SYNC sends 00000001 (LSB first), producing KJKJKJKK on the line.
- REQ-014: NRZI: a 0 toggles J/K; a 1 holds. The NRZI state starts at J.
- REQ-015: Byte load points: first Clk of the last SYNC bit cell, and first Clk of bit 7 of each DATA byte.
- REQ-016: At a load point with TxValid=1: TxReady=1 for that Clk and TxData is latched.
- REQ-017: At a load point with TxValid=0: no TxReady; after the current byte, go to CRC (macro) or EOP_SE0.
- REQ-018: Bit stuffing: after six consecutive 1s, insert one 0 bit cell; the data shifter stalls for that cell.
- REQ-019: The stuff counter counts from the SYNC final 1 and clears on every 0, real or stuffed.
- REQ-020: A stuff bit due after the last data or CRC bit is sent before EOP.
- REQ-021: EOP_SE0 drives SE0 for 2 bit cells; EOP_J drives J for 1 bit cell; then OE=0 and IDLE.
- REQ-022: Busy and OE fall in the same Clk.
- REQ-023: TxValid changes during SYNC or EOP are ignored.
- REQ-024: Back-to-back packets: TxValid=1 in the IDLE Clk after EOP starts a new SYNC.

Reset
- REQ-025: Reset low forces IDLE asynchronously: OE=0, Busy=0, TxReady=0, lines=J, stuff counter=0, NRZI state=J.
- REQ-026: Reset low mid-packet abandons the packet with no EOP.
- REQ-027: On reset release, the block waits in IDLE for TxValid.

Configuration
- REQ-028: USB_TX_CRC16_EN defined: a CRC16 is computed over all DATA bytes and appended in the CRC state.
  - CRC16 polynomial x^16+x^15+x^2+1, init 0xFFFF, sent complemented, LSB first, 16 bits, stuffed.
  - The CRC does not include the first byte (PID).
- REQ-029: USB_TX_CRC16_EN undefined: CRC state and logic are absent; the client supplies CRC bytes as data.

Structure
- REQ-030: Shared package usb_pkg holds: line-state constants J/K/SE0, SYNC pattern, CRC16 polynomial and init, state encoding.
- REQ-031: One sub-module, usb_crc16: serial, 1 bit/enable, clear input, 16-bit output; instantiated only under USB_TX_CRC16_EN.

Verification
- REQ-032: Single byte 0xA5, no CRC, CLKS_PER_BIT=4 -> KJKJKJKK, then NRZI of 1,0,1,0,0,1,0,1, SE0 SE0 J; OE high 76 Clks; one TxReady pulse.
- REQ-033: Byte 0xFF -> stuffed 0 after 5th data bit (SYNC 1 counts), 17 bit cells before EOP; OE high 80 Clks.
- REQ-034: Three bytes 0x2D,0x00,0x10 -> exactly 3 TxReady pulses, each 32 Clks apart; TxValid dropped after 3rd -> EOP.
- REQ-035: Reset low during 2nd data byte -> OE=0 and lines=J in the same Clk; next TxValid gives a clean SYNC.
- REQ-036: With USB_TX_CRC16_EN, PID 0xC3 then data 0x00,0x01 -> CRC bytes match the reference model CRC of 0x00,0x01 and are sent before EOP.
- REQ-037: TxValid held high after EOP -> new SYNC starts one Clk after OE falls; no SE0 glitch between packets.
